inter_frame_space: RTL and testbench

// - CAN inter-frame-space tracker between the frame maker and the bit-timing unit.
// - After a frame (or overload frame) ends, it counts the intermission bits and then holds bus-idle.
// - On a dominant bit (canRX=0) it flags an overload condition or a start of frame.
// - All bus decisions are taken only on samplePoint strobes.

---
 rtl/inter_frame_space.sv | 109 ++++++++++
 tb/tb_inter_frame_space.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inter_frame_space.sv
// CAN inter-frame-space tracker: counts intermission bits after a frame and reports
// overload, start-of-frame and bus-idle. Optional suspend-transmission: `define IFS_SUSPEND_EN.
module inter_frame_space #(
    parameter int INTERMISSION_BITS = 3,
    parameter int SUSPEND_BITS      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic samplePoint,
    input  logic canRX,
    input  logic frameReady,
    input  logic endOverload,
`ifdef IFS_SUSPEND_EN
    input  logic errorPassive,
`endif
    output logic isOverload,
    output logic isStart,
    output logic busIdle
);

    typedef enum logic [2:0] {
        IDLE,
        INTERMISSION,
        OVERLOAD,
        FRAME
`ifdef IFS_SUSPEND_EN
        , SUSPEND
`endif
    } state_t;

    localparam logic [2:0] LAST_INTERMISSION = 3'(INTERMISSION_BITS - 1);
`ifdef IFS_SUSPEND_EN
    localparam logic [2:0] LAST_SUSPEND = 3'(SUSPEND_BITS - 1);
`endif

    state_t     state;
    logic [2:0] cnt;

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            isOverload <= 1'b0;
            isStart    <= 1'b0;
        end else begin
            isOverload <= 1'b0;
            isStart    <= 1'b0;
            if (frameReady) begin
                state <= INTERMISSION;
                cnt   <= 3'd0;
            end else if (endOverload && state == OVERLOAD) begin
                state <= INTERMISSION;
                cnt   <= 3'd0;
            end else if (samplePoint) begin
                case (state)
                    IDLE: begin
                        if (!canRX) begin
                            isStart <= 1'b1;
                            state   <= FRAME;
                        end
                    end
                    INTERMISSION: begin
                        if (cnt < LAST_INTERMISSION) begin
                            if (!canRX) begin
                                isOverload <= 1'b1;
                                state      <= OVERLOAD;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end else begin
                            // A dominant bit in the last intermission bit is a start of frame.
                            cnt <= 3'd0;
                            if (!canRX) begin
                                isStart <= 1'b1;
                                state   <= FRAME;
`ifdef IFS_SUSPEND_EN
                            end else if (errorPassive) begin
                                state <= SUSPEND;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
`ifdef IFS_SUSPEND_EN
                    SUSPEND: begin
                        if (!canRX) begin
                            isStart <= 1'b1;
                            state   <= FRAME;
                            cnt     <= 3'd0;
                        end else if (cnt == LAST_SUSPEND) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
`endif
                    // OVERLOAD and FRAME ignore the bus until a frame/overload end pulse.
                    default: ;
                endcase
            end
        end
    end

    assign busIdle = (state == IDLE);

endmodule

// File: tb/tb_inter_frame_space.sv
// Scoreboard bench for inter_frame_space: stimulus queues expected pulses, a monitor
// pops and compares them; busIdle levels are checked directly at chosen points.
module tb_inter_frame_space;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic samplePoint = 1'b0;
    logic canRX = 1'b1;
    logic frameReady = 1'b0;
    logic endOverload = 1'b0;
`ifdef IFS_SUSPEND_EN
    logic errorPassive = 1'b0;
`endif
    logic isOverload;
    logic isStart;
    logic busIdle;

    inter_frame_space dut (
        .clock       (clock),
        .reset       (reset),
        .samplePoint (samplePoint),
        .canRX       (canRX),
        .frameReady  (frameReady),
        .endOverload (endOverload),
`ifdef IFS_SUSPEND_EN
        .errorPassive(errorPassive),
`endif
        .isOverload  (isOverload),
        .isStart     (isStart),
        .busIdle     (busIdle)
    );

    always #5 clock = ~clock;

    typedef enum int { EV_START = 0, EV_OVERLOAD = 1 } ev_t;
    typedef struct { ev_t kind; int stamp; } exp_t;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic check(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Expected pulse appears after the next rising edge; monitor sees it at the following negedge.
    task automatic expectPulse(input ev_t kind);
        exp_t e;
        e.kind  = kind;
        e.stamp = cycleCount + 1;
        expQ.push_back(e);
    endtask

    always @(negedge clock) begin
        if (isStart === 1'b1 && isOverload === 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("FAIL both_pulses: isStart=1 isOverload=1 at cycle %0d, expected at most one", cycleCount);
        end else if (isStart === 1'b1 || isOverload === 1'b1) begin
            exp_t e;
            ev_t  got;
            got = isStart ? EV_START : EV_OVERLOAD;
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", got, cycleCount);
            end else begin
                e = expQ.pop_front();
                if (e.kind != got || e.stamp != cycleCount) begin
                    testsFailed++;
                    $display("FAIL pulse: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                             got, cycleCount, e.kind, e.stamp);
                end
            end
        end
    end

    task automatic strobe(input logic rx, input logic pulse = 1'b0);
        @(negedge clock);
        samplePoint = 1'b1;
        canRX       = rx;
        if (pulse) begin
            if (!rx) expectPulse(EV_START);
        end
        @(negedge clock);
        samplePoint = 1'b0;
        canRX       = 1'b1;
    endtask

    task automatic strobeOverload();
        @(negedge clock);
        samplePoint = 1'b1;
        canRX       = 1'b0;
        expectPulse(EV_OVERLOAD);
        @(negedge clock);
        samplePoint = 1'b0;
        canRX       = 1'b1;
    endtask

    task automatic pulseFrameReady();
        @(negedge clock);
        frameReady = 1'b1;
        @(negedge clock);
        frameReady = 1'b0;
    endtask

    task automatic pulseEndOverload();
        @(negedge clock);
        endOverload = 1'b1;
        @(negedge clock);
        endOverload = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_busIdle", busIdle, 1'b1);
        check("reset_isStart", isStart, 1'b0);
        check("reset_isOverload", isOverload, 1'b0);

        // Dominant strobes from IDLE: only the first is SOF.
        strobe(1'b0, 1'b1);
        check("sof_busIdle", busIdle, 1'b0);
        repeat (9) strobe(1'b0);
        check("frame_holds", busIdle, 1'b0);

        // Clean intermission reaches IDLE on the third recessive bit.
        pulseFrameReady();
        check("im_start_busIdle", busIdle, 1'b0);
        strobe(1'b1);
        strobe(1'b1);
        check("im_bit2_busIdle", busIdle, 1'b0);
        strobe(1'b1);
        check("im_done_busIdle", busIdle, 1'b1);

        // Dominant in the second intermission bit: overload.
        pulseFrameReady();
        strobe(1'b1);
        strobeOverload();
        check("ovl_busIdle", busIdle, 1'b0);
        strobe(1'b0);
        strobe(1'b1);
        pulseEndOverload();
        strobe(1'b1);
        strobe(1'b1);
        check("ovl_im_bit2_busIdle", busIdle, 1'b0);
        strobe(1'b1);
        check("ovl_im_done_busIdle", busIdle, 1'b1);

        // endOverload outside OVERLOAD is ignored.
        pulseEndOverload();
        check("endovl_ignored_idle", busIdle, 1'b1);

        // Dominant in the last intermission bit: SOF.
        pulseFrameReady();
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0, 1'b1);
        check("last_bit_sof_busIdle", busIdle, 1'b0);

        // frameReady wins over a same-cycle dominant strobe; intermission restarts from 0.
        @(negedge clock);
        frameReady  = 1'b1;
        samplePoint = 1'b1;
        canRX       = 1'b0;
        @(negedge clock);
        frameReady  = 1'b0;
        samplePoint = 1'b0;
        canRX       = 1'b1;
        strobe(1'b1);
        strobe(1'b1);
        check("same_cycle_bit2_busIdle", busIdle, 1'b0);
        strobe(1'b1);
        check("same_cycle_done_busIdle", busIdle, 1'b1);

        // Reset in mid-intermission returns to IDLE next cycle.
        pulseFrameReady();
        strobe(1'b1);
        check("pre_reset_busIdle", busIdle, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_im_reset_busIdle", busIdle, 1'b1);
        strobe(1'b0, 1'b1);
        check("post_reset_sof_busIdle", busIdle, 1'b0);

`ifdef IFS_SUSPEND_EN
        // Error-passive node: 3 intermission + 8 suspend bits before IDLE.
        errorPassive = 1'b1;
        pulseFrameReady();
        repeat (3) strobe(1'b1);
        check("susp_entered_busIdle", busIdle, 1'b0);
        repeat (7) strobe(1'b1);
        check("susp_bit7_busIdle", busIdle, 1'b0);
        strobe(1'b1);
        check("susp_done_busIdle", busIdle, 1'b1);

        // Dominant sample inside SUSPEND is SOF.
        pulseFrameReady();
        repeat (3) strobe(1'b1);
        repeat (2) strobe(1'b1);
        strobe(1'b0, 1'b1);
        check("susp_sof_busIdle", busIdle, 1'b0);
        errorPassive = 1'b0;
`endif

        repeat (3) @(negedge clock);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
